// File: rtl/alu_share_if.sv
// Bundle of requester, ALU and result-stage signals shared by alu_share_arbiter
// and its environment; W is the operand/result datapath width.
interface alu_share_if #(
    parameter int W = 256
);
    logic         r0_valid, r1_valid;
    logic         r0_ready, r1_ready;
    logic [2:0]   r0_op,    r1_op;
    logic         r0_vsel,  r1_vsel;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic         r0_last,  r1_last;

    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_ctrl;
    logic         alu_vsel;
    logic [W-1:0] alu_result;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_id;
    logic         res_last;

    modport slave (
        input  r0_valid, r1_valid, r0_op, r1_op, r0_vsel, r1_vsel,
        input  r0_a, r0_b, r1_a, r1_b, r0_last, r1_last,
        output r0_ready, r1_ready,
        output alu_a, alu_b, alu_ctrl, alu_vsel,
        input  alu_result,
        output res_valid, res_data, res_id, res_last,
        input  res_ready
    );

    modport master (
        output r0_valid, r1_valid, r0_op, r1_op, r0_vsel, r1_vsel,
        output r0_a, r0_b, r1_a, r1_b, r0_last, r1_last,
        input  r0_ready, r1_ready,
        input  alu_a, alu_b, alu_ctrl, alu_vsel,
        output alu_result,
        input  res_valid, res_data, res_id, res_last,
        output res_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter for the shared SIMD ALU with locked bursts and a
// one-entry result stage. Define ALU_ARB_FIXED_PRIO_EN for fixed r0 priority.
module alu_share_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    alu_share_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   grant0, grant1;
    logic   slot_free;
    logic   acc0, acc1, accept, acc_last;
    logic   rr_pick;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign rr_pick = 1'b0;
`else
    logic rr;

    // After a completed transaction the other requester becomes preferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 rr <= 1'b0;
        else if (accept && acc_last) rr <= acc0;
    end

    assign rr_pick = rr;
`endif

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.r0_valid && bus.r1_valid) begin
                    grant0 = !rr_pick;
                    grant1 = rr_pick;
                end else begin
                    grant0 = bus.r0_valid;
                    grant1 = bus.r1_valid;
                end
            end
            LOCK0:   grant0 = bus.r0_valid;
            LOCK1:   grant1 = bus.r1_valid;
            default: ;
        endcase
    end

    assign slot_free = !bus.res_valid || bus.res_ready;

    // Readies are held low while reset is asserted, not only after it releases.
    assign acc0     = rst_n && grant0 && bus.r0_valid && slot_free;
    assign acc1     = rst_n && grant1 && bus.r1_valid && slot_free;
    assign accept   = acc0 || acc1;
    assign acc_last = acc1 ? bus.r1_last : bus.r0_last;

    assign bus.r0_ready = acc0;
    assign bus.r1_ready = acc1;

    assign bus.alu_a    = grant0 ? bus.r0_a    : grant1 ? bus.r1_a    : '0;
    assign bus.alu_b    = grant0 ? bus.r0_b    : grant1 ? bus.r1_b    : '0;
    assign bus.alu_ctrl = grant0 ? bus.r0_op   : grant1 ? bus.r1_op   : 3'b000;
    assign bus.alu_vsel = grant0 ? bus.r0_vsel : grant1 ? bus.r1_vsel : 1'b0;

    always_comb begin
        state_nxt = state;
        if (accept) begin
            if (state == IDLE) begin
                if (!acc_last) state_nxt = acc1 ? LOCK1 : LOCK0;
            end else if (acc_last) begin
                state_nxt = IDLE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the result register is reset so a reset discards any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_id    <= 1'b0;
            bus.res_last  <= 1'b0;
        end else if (accept) begin
            bus.res_valid <= 1'b1;
            bus.res_data  <= bus.alu_result;
            bus.res_id    <= acc1;
            bus.res_last  <= acc_last;
        end else if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter; a small ALU model feeds alu_result.
// Build with ALU_ARB_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_alu_share_arbiter;

    localparam int W = 256;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    logic exp_rr;

    alu_share_if #(.W(W)) bus ();

    alu_share_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_ctrl)
            3'b000: bus.alu_result = bus.alu_a + bus.alu_b;
            3'b001: bus.alu_result = bus.alu_a - bus.alu_b;
            3'b010: bus.alu_result = bus.alu_a & bus.alu_b;
            3'b011: bus.alu_result = bus.alu_vsel ? bus.alu_a * bus.alu_b : bus.alu_a | bus.alu_b;
            3'b101: bus.alu_result = {bus.alu_a[W-2:0], bus.alu_a[W-1]};
            default: bus.alu_result = '0;
        endcase
    end

    function automatic logic pick();
`ifdef ALU_ARB_FIXED_PRIO_EN
        return 1'b0;
`else
        return exp_rr;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_r0(input logic v, input logic [2:0] op, input logic vsel,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        bus.r0_valid = v; bus.r0_op = op; bus.r0_vsel = vsel;
        bus.r0_a = a; bus.r0_b = b; bus.r0_last = last;
    endtask

    task automatic drive_r1(input logic v, input logic [2:0] op, input logic vsel,
                            input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        bus.r1_valid = v; bus.r1_op = op; bus.r1_vsel = vsel;
        bus.r1_a = a; bus.r1_b = b; bus.r1_last = last;
    endtask

    task automatic clear_reqs();
        drive_r0(1'b0, 3'b000, 1'b0, '0, '0, 1'b0);
        drive_r1(1'b0, 3'b000, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.res_ready = 1'b1;
        drive_r0(1'b1, 3'b000, 1'b0, 256'd1, 256'd2, 1'b1);
        drive_r1(1'b1, 3'b000, 1'b0, 256'd3, 256'd4, 1'b1);
        repeat (3) step();
        tests++;
        if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready: got %b%b expected 00", bus.r0_ready, bus.r1_ready);
        end
        tests++;
        if (bus.res_valid !== 1'b0) begin
            fails++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid);
        end
        tests++;
        if (bus.res_data !== '0) begin
            fails++; $display("FAIL reset_res_data: got %h expected 0", bus.res_data);
        end
        exp_rr = 1'b0;
    endtask

    task automatic test_single_add();
        drive_r0(1'b1, 3'b000, 1'b0, 256'h00010008, 256'h00008004, 1'b1);
        drive_r1(1'b0, 3'b000, 1'b0, '0, '0, 1'b0);
        rst_n = 1'b1;
        #1;
        tests++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            fails++; $display("FAIL single_ready: got r0=%b r1=%b expected r0=1 r1=0", bus.r0_ready, bus.r1_ready);
        end
        tests++;
        if (bus.alu_a !== 256'h00010008 || bus.alu_ctrl !== 3'b000) begin
            fails++; $display("FAIL single_alu_drive: got a=%h ctrl=%b", bus.alu_a, bus.alu_ctrl);
        end
        step();
        exp_rr = 1'b1;
        tests++;
        if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b0 || bus.res_data[31:0] !== 32'h0001800C) begin
            fails++; $display("FAIL single_result: got v=%b id=%b d=%h expected v=1 id=0 d=0001800c",
                              bus.res_valid, bus.res_id, bus.res_data[31:0]);
        end
        clear_reqs();
        #1;
        tests++;
        if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_ctrl !== 3'b000 || bus.alu_vsel !== 1'b0) begin
            fails++; $display("FAIL idle_alu_zero: got a=%h ctrl=%b vsel=%b expected zeros",
                              bus.alu_a, bus.alu_ctrl, bus.alu_vsel);
        end
        step();
    endtask

    task automatic test_contention();
        logic         exp_id;
        logic [W-1:0] exp_data;
        // A lone r1 request first, so the round-robin pointer prefers r0 again.
        drive_r1(1'b1, 3'b001, 1'b0, 256'd50, 256'd8, 1'b1);
        #1;
        tests++;
        if (bus.r1_ready !== 1'b1) begin
            fails++; $display("FAIL lone_r1_ready: got %b expected 1", bus.r1_ready);
        end
        step();
        exp_rr = 1'b0;
        tests++;
        if (bus.res_id !== 1'b1 || bus.res_data !== 256'd42) begin
            fails++; $display("FAIL lone_r1_result: got id=%b d=%0d expected id=1 d=42", bus.res_id, bus.res_data);
        end
        for (int i = 0; i < 4; i++) begin
            drive_r0(1'b1, 3'b000, 1'b0, W'(i + 1), 256'd16, 1'b1);
            drive_r1(1'b1, 3'b001, 1'b0, 256'd100, W'(i), 1'b1);
            exp_id   = pick();
            exp_data = exp_id ? W'(100 - i) : W'(i + 17);
            #1;
            tests++;
            if (bus.r0_ready !== !exp_id || bus.r1_ready !== exp_id) begin
                fails++; $display("FAIL contention_grant[%0d]: got r0=%b r1=%b expected id %0d",
                                  i, bus.r0_ready, bus.r1_ready, exp_id);
            end
            step();
            exp_rr = !exp_id;
            tests++;
            if (bus.res_id !== exp_id || bus.res_data !== exp_data) begin
                fails++; $display("FAIL contention_result[%0d]: got id=%b d=%0d expected id=%b d=%0d",
                                  i, bus.res_id, bus.res_data, exp_id, exp_data);
            end
        end
        clear_reqs();
        step();
    endtask

    task automatic test_locked_burst();
        logic [W-1:0] exp_data;
        for (int k = 0; k < 3; k++) begin
            drive_r1(1'b1, 3'b011, 1'b1, W'(3 + k), 256'd7, (k == 2));
            if (k > 0) drive_r0(1'b1, 3'b000, 1'b0, 256'd1, 256'd1, 1'b1);
            exp_data = W'((3 + k) * 7);
            #1;
            tests++;
            if (bus.r1_ready !== 1'b1 || bus.r0_ready !== 1'b0 || bus.alu_vsel !== 1'b1 || bus.alu_ctrl !== 3'b011) begin
                fails++; $display("FAIL burst_grant[%0d]: got r0=%b r1=%b vsel=%b ctrl=%b",
                                  k, bus.r0_ready, bus.r1_ready, bus.alu_vsel, bus.alu_ctrl);
            end
            step();
            tests++;
            if (bus.res_id !== 1'b1 || bus.res_last !== (k == 2) || bus.res_data !== exp_data) begin
                fails++; $display("FAIL burst_result[%0d]: got id=%b last=%b d=%0d expected id=1 last=%b d=%0d",
                                  k, bus.res_id, bus.res_last, bus.res_data, (k == 2), exp_data);
            end
        end
        exp_rr = 1'b0;
        drive_r1(1'b0, 3'b000, 1'b0, '0, '0, 1'b0);
        #1;
        tests++;
        if (bus.r0_ready !== 1'b1) begin
            fails++; $display("FAIL burst_release_r0: got %b expected 1", bus.r0_ready);
        end
        step();
        exp_rr = 1'b1;
        tests++;
        if (bus.res_id !== 1'b0 || bus.res_data !== 256'd2 || bus.res_last !== 1'b1) begin
            fails++; $display("FAIL burst_after_r0: got id=%b d=%0d last=%b expected id=0 d=2 last=1",
                              bus.res_id, bus.res_data, bus.res_last);
        end
        clear_reqs();
        step();
    endtask

    task automatic test_backpressure();
        logic         exp_id;
        logic [W-1:0] exp_data;
        drive_r0(1'b1, 3'b000, 1'b0, 256'd5, 256'd6, 1'b1);
        step();
        exp_rr = 1'b1;
        bus.res_ready = 1'b0;
        drive_r0(1'b1, 3'b000, 1'b0, 256'd9, 256'd9, 1'b1);
        drive_r1(1'b1, 3'b001, 1'b0, 256'd40, 256'd1, 1'b1);
        exp_id   = pick();
        exp_data = exp_id ? 256'd39 : 256'd18;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests++;
            if (bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0 || bus.alu_a !== (exp_id ? 256'd40 : 256'd9)) begin
                fails++; $display("FAIL bp_stall[%0d]: got r0=%b r1=%b alu_a=%0d",
                                  c, bus.r0_ready, bus.r1_ready, bus.alu_a);
            end
            step();
            tests++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== 256'd11) begin
                fails++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d expected v=1 d=11", c, bus.res_valid, bus.res_data);
            end
        end
        bus.res_ready = 1'b1;
        #1;
        tests++;
        if (bus.r0_ready !== !exp_id || bus.r1_ready !== exp_id) begin
            fails++; $display("FAIL bp_release_grant: got r0=%b r1=%b expected id %0d", bus.r0_ready, bus.r1_ready, exp_id);
        end
        step();
        exp_rr = !exp_id;
        tests++;
        if (bus.res_valid !== 1'b1 || bus.res_id !== exp_id || bus.res_data !== exp_data) begin
            fails++; $display("FAIL bp_release_result: got v=%b id=%b d=%0d expected v=1 id=%b d=%0d",
                              bus.res_valid, bus.res_id, bus.res_data, exp_id, exp_data);
        end
        clear_reqs();
        step();
    endtask

    task automatic test_reset_mid_burst();
        drive_r0(1'b1, 3'b000, 1'b0, 256'd2, 256'd2, 1'b1);
        step();
        exp_rr = 1'b1;
        drive_r0(1'b0, 3'b000, 1'b0, '0, '0, 1'b0);
        drive_r1(1'b1, 3'b001, 1'b0, 256'd10, 256'd3, 1'b0);
        step();
        // r1 now owns the ALU; r0 must starve while r1 is idle mid-burst.
        drive_r1(1'b0, 3'b000, 1'b0, '0, '0, 1'b0);
        drive_r0(1'b1, 3'b000, 1'b0, 256'd4, 256'd4, 1'b1);
        #1;
        tests++;
        if (bus.r0_ready !== 1'b0 || bus.res_data !== 256'd7) begin
            fails++; $display("FAIL lock_starve: got r0=%b d=%0d expected r0=0 d=7", bus.r0_ready, bus.res_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.res_valid !== 1'b0 || bus.r0_ready !== 1'b0 || bus.res_data !== '0) begin
            fails++; $display("FAIL midreset_clear: got v=%b r0=%b d=%0d expected 0 0 0",
                              bus.res_valid, bus.r0_ready, bus.res_data);
        end
        step();
        exp_rr = 1'b0;
        rst_n = 1'b1;
        drive_r1(1'b1, 3'b000, 1'b0, 256'd8, 256'd8, 1'b1);
        #1;
        tests++;
        if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
            fails++; $display("FAIL midreset_r0_wins: got r0=%b r1=%b expected r0=1 r1=0", bus.r0_ready, bus.r1_ready);
        end
        step();
        tests++;
        if (bus.res_id !== 1'b0 || bus.res_data !== 256'd8) begin
            fails++; $display("FAIL midreset_result: got id=%b d=%0d expected id=0 d=8", bus.res_id, bus.res_data);
        end
        clear_reqs();
        step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        exp_rr = 1'b0;
        bus.res_ready = 1'b1;
        clear_reqs();
        test_reset();
        test_single_add();
        test_contention();
        test_locked_burst();
        test_backpressure();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
